// File: rtl/id_ex_stage.sv
// id_ex_stage: MIPS decode/issue stage with ID/EX pipeline register and load-use bubble insertion.
// Optional macro ID_STALL_CNT_EN adds a wrapping load-use stall counter on stall_count.
module id_ex_stage #(
  parameter logic [31:0] NOP_PC = 32'h0,
  parameter int unsigned CNT_W  = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             if_valid,
  input  logic [31:0]      if_instr,
  input  logic [31:0]      if_pc,
  output logic             id_ready,
  output logic [4:0]       rf_addr1,
  output logic [4:0]       rf_addr2,
  input  logic [31:0]      rf_data1,
  input  logic [31:0]      rf_data2,
  input  logic             ex_stall,
  input  logic             flush,
  output logic             ex_valid,
  output logic [31:0]      ex_pc,
  output logic [5:0]       ex_opcode,
  output logic [5:0]       ex_funct,
  output logic [4:0]       ex_shamt,
  output logic [4:0]       ex_rs,
  output logic [4:0]       ex_rt,
  output logic [31:0]      ex_rs_val,
  output logic [31:0]      ex_rt_val,
  output logic [31:0]      ex_imm,
  output logic [4:0]       ex_dest,
  output logic             ex_reg_write,
  output logic             ex_mem_read,
  output logic             ex_mem_write,
  output logic [CNT_W-1:0] stall_count
);
  typedef struct packed {
    logic [31:0] pc;
    logic [5:0]  op;
    logic [5:0]  funct;
    logic [4:0]  shamt;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic [31:0] imm;
    logic [4:0]  dest;
  } data_t;
  typedef struct packed {
    logic valid;
    logic reg_write;
    logic mem_read;
    logic mem_write;
  } ctl_t;
  logic [5:0] op, fn;
  logic [4:0] rs, rt, dest;
  logic       rw, uses_rs, uses_rt, hazard, take, hold;
  data_t      data_q, data_d, data_new;
  ctl_t       ctl_q, ctl_d, ctl_new;
  assign op       = if_instr[31:26];
  assign fn       = if_instr[5:0];
  assign rs       = if_instr[25:21];
  assign rt       = if_instr[20:16];
  assign rf_addr1 = rs;
  assign rf_addr2 = rt;
  assign dest = op == 6'h00 ? if_instr[15:11] : op == 6'h03 ? 5'd31 : rt;
  assign rw   = ((op == 6'h00 && fn != 6'h08) || op == 6'h03 ||
                 op inside {[6'h08:6'h0f]} || op == 6'h23) && dest != 5'd0;
  assign uses_rs = !(op inside {6'h02, 6'h03, 6'h0f});
  assign uses_rt = op inside {6'h00, 6'h04, 6'h05, 6'h2b};
  // Only a load still sitting in ID/EX can produce a value too late for forwarding
  assign hazard = if_valid && ctl_q.valid && ctl_q.mem_read && data_q.dest != 5'd0 &&
                  ((uses_rs && data_q.dest == rs) || (uses_rt && data_q.dest == rt));
  assign id_ready = !ex_stall && !hazard && !flush;
  assign take     = id_ready && if_valid;
  assign hold     = !flush && ex_stall;
  always_comb begin
    data_new = '{
      pc:     if_pc,
      op:     op,
      funct:  fn,
      shamt:  if_instr[10:6],
      rs:     rs,
      rt:     rt,
      rs_val: rf_data1,
      rt_val: rf_data2,
      imm:    op inside {6'h0c, 6'h0d, 6'h0e} ? {16'h0, if_instr[15:0]}
                                              : {{16{if_instr[15]}}, if_instr[15:0]},
      dest:   dest
    };
    ctl_new = '{valid: 1'b1, reg_write: rw, mem_read: op == 6'h23, mem_write: op == 6'h2b};
    data_d  = take ? data_new : data_q;
    ctl_d   = hold ? ctl_q : take ? ctl_new : '0;
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      data_q <= '{pc: NOP_PC, default: '0};
      ctl_q  <= '0;
    end else begin
      data_q <= data_d;
      ctl_q  <= ctl_d;
    end
  end
`ifdef ID_STALL_CNT_EN
  logic [CNT_W-1:0] cnt_q;
  always_ff @(posedge clk) begin
    cnt_q <= !reset ? '0 : (hazard && !flush && !ex_stall) ? cnt_q + CNT_W'(1) : cnt_q;
  end
  assign stall_count = cnt_q;
`else
  assign stall_count = '0;
`endif
  assign ex_valid     = ctl_q.valid;
  assign ex_reg_write = ctl_q.reg_write;
  assign ex_mem_read  = ctl_q.mem_read;
  assign ex_mem_write = ctl_q.mem_write;
  assign ex_pc        = data_q.pc;
  assign ex_opcode    = data_q.op;
  assign ex_funct     = data_q.funct;
  assign ex_shamt     = data_q.shamt;
  assign ex_rs        = data_q.rs;
  assign ex_rt        = data_q.rt;
  assign ex_rs_val    = data_q.rs_val;
  assign ex_rt_val    = data_q.rt_val;
  assign ex_imm       = data_q.imm;
  assign ex_dest      = data_q.dest;
endmodule
